ami_bram_responder: RTL and testbench

Synthesizable memory responder for the AMI request/response protocol: the device on the far end of a `MemReq`/`MemResp` channel. It accepts read and write requests under a grant handshake, stores 512-bit words in an on-chip array, and returns read data in request order through a buffered response port. It plugs in wherever a SimpleDRAM channel is expected, for example behind an AmorphOSMem `ch2sdram_*` port. It serves as a BRAM-backed channel in FPGA builds and as a fixed-latency target for AMI benches.

---
 rtl/ami_bram_responder_pkg.sv | 13 +
 rtl/ami_types_pkg.sv | 20 ++
 rtl/ami_bram_responder_if.sv | 25 ++
 rtl/ami_bram_responder_resp_fifo.sv | 62 ++++++
 rtl/ami_bram_responder.sv | 138 +++++++++++++
 tb/tb_ami_bram_responder.sv | 303 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ami_bram_responder_pkg.sv
// Local helpers for the BRAM responder: byte-to-word address conversion.
package ami_bram_responder_pkg;
  import AMITypes::*;

  // Byte offset bits inside one AMI word.
  localparam int WORD_SHIFT = $clog2(AMI_WORD_BYTES);

  // Byte address to word address; the caller keeps only the index bits it needs.
  function automatic logic [AMI_ADDR_WIDTH-1:0] word_addr(input logic [AMI_ADDR_WIDTH-1:0] byte_addr);
    return byte_addr >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/ami_types_pkg.sv
// Shared AMI request/response types used by every AMI channel endpoint.
package AMITypes;

  localparam int AMI_ADDR_WIDTH = 64;
  localparam int AMI_DATA_WIDTH = 512;
  localparam int AMI_WORD_BYTES = 64;

  typedef struct packed {
    logic                      valid;
    logic                      isWrite;
    logic [AMI_ADDR_WIDTH-1:0] addr;
    logic [AMI_DATA_WIDTH-1:0] data;
  } MemReq;

  typedef struct packed {
    logic                      valid;
    logic [AMI_DATA_WIDTH-1:0] data;
  } MemResp;

endpackage

// File: rtl/ami_bram_responder_if.sv
// AMI MemReq/MemResp channel bundle. The master issues requests and consumes
// responses; the slave (the memory) grants requests and produces responses.
interface ami_bram_responder_if;
  import AMITypes::*;

  MemReq  mem_req_in;
  logic   mem_req_grant_out;
  MemResp mem_resp_out;
  logic   mem_resp_grant_in;

  modport master (
    output mem_req_in,
    output mem_resp_grant_in,
    input  mem_req_grant_out,
    input  mem_resp_out
  );

  modport slave (
    input  mem_req_in,
    input  mem_resp_grant_in,
    output mem_req_grant_out,
    output mem_resp_out
  );

endinterface

// File: rtl/ami_bram_responder_resp_fifo.sv
// First-word-fall-through FIFO for AMI response paths. The head entry is
// presented combinationally from storage; a push into an empty FIFO shows up
// the following cycle. Push and pop in the same cycle both succeed, and a push
// into a full FIFO is accepted only when a pop frees a slot that same cycle.
module ami_resp_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int LOG_Q_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [LOG_Q_SIZE:0]   count
);

  localparam int DEPTH = 1 << LOG_Q_SIZE;
  localparam logic [LOG_Q_SIZE:0] PTR_ONE   = {{LOG_Q_SIZE{1'b0}}, 1'b1};
  localparam logic [LOG_Q_SIZE:0] FULL_CNT  = {1'b1, {LOG_Q_SIZE{1'b0}}};

  logic [DATA_WIDTH-1:0] store [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [LOG_Q_SIZE:0]   wr_ptr;
  logic [LOG_Q_SIZE:0]   rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr[LOG_Q_SIZE-1:0]];

  // Pointer advance; storage contents need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry write at the tail slot.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[LOG_Q_SIZE-1:0]] <= push_data;
  end

  // Dropping a push silently would lose a response; flag it loudly instead.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !do_pop))
        else $error("ami_resp_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/ami_bram_responder.sv
// BRAM-backed AMI memory responder. Accepts reads and writes under a credit
// based grant, stores words in an on-chip array, and returns read data in
// request order through a response FIFO.
//
// Read timing: the array read is registered into stage 1 at the accepting
// edge; stages 1..READ_LATENCY-1 are plain shift registers and the last one
// pushes into the FIFO, whose register is the final stage. A read accepted at
// the edge ending cycle N is therefore visible at the FIFO head in cycle
// N+READ_LATENCY. With READ_LATENCY == 1 the array is read combinationally
// straight into the FIFO.
module ami_bram_responder
  import AMITypes::*;
  import ami_bram_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int LOG_SIZE     = 10,
  parameter int LOG_Q_SIZE   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  ami_bram_responder_if.slave bus
);

  localparam int WORDS = 1 << LOG_SIZE;
  // Registered stages ahead of the FIFO; kept at least 1 so the arrays exist.
  localparam int NSTG  = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [LOG_Q_SIZE:0] CRED_ONE = {{LOG_Q_SIZE{1'b0}}, 1'b1};
  localparam logic [LOG_Q_SIZE:0] CRED_MAX = {1'b1, {LOG_Q_SIZE{1'b0}}};

  // Word storage; no reset so it maps onto block RAM and survives rst.
  logic [DATA_WIDTH-1:0]           mem [WORDS];

  logic [AMI_ADDR_WIDTH-1:0]       req_waddr;
  logic [LOG_SIZE-1:0]             req_idx;
  logic                            grant;
  logic                            req_fire;
  logic                            rd_fire;
  logic                            wr_fire;

  logic [NSTG:1]                   vld_pipe;
  logic [NSTG:1][DATA_WIDTH-1:0]   dat_pipe;
  logic                            tail_vld;
  logic [DATA_WIDTH-1:0]           tail_dat;

  // Reads in the pipeline plus entries held in the FIFO.
  logic [LOG_Q_SIZE:0]             outstanding;

  logic [DATA_WIDTH-1:0]           fifo_head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [LOG_Q_SIZE:0]             fifo_count;
  logic                            resp_vld;
  logic                            consume;

  // Only the low index bits select a word; higher bits wrap.
  logic                            unused_addr_hi;

  assign req_waddr      = word_addr(bus.mem_req_in.addr);
  assign req_idx        = req_waddr[LOG_SIZE-1:0];
  assign unused_addr_hi = ^req_waddr[AMI_ADDR_WIDTH-1:LOG_SIZE];

  // Grant depends only on registered state: a read can always find a FIFO slot.
  assign grant    = !rst && (outstanding < CRED_MAX);
  assign req_fire = bus.mem_req_in.valid && grant;
  assign rd_fire  = req_fire && !bus.mem_req_in.isWrite;
  assign wr_fire  = req_fire &&  bus.mem_req_in.isWrite;

  assign bus.mem_req_grant_out = grant;

  // Array write plus registered read feeding the first pipeline stage.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[req_idx] <= bus.mem_req_in.data;
    dat_pipe[1] <= mem[req_idx];
    for (int s = 2; s <= NSTG; s++) dat_pipe[s] <= dat_pipe[s-1];
  end

  // Valid tags travelling alongside the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_fire;
      for (int s = 2; s <= NSTG; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Pick the FIFO push source according to the configured latency.
  if (READ_LATENCY == 1) begin : g_lat1
    assign tail_vld = rd_fire;
    assign tail_dat = mem[req_idx];
  end else begin : g_latn
    assign tail_vld = vld_pipe[NSTG];
    assign tail_dat = dat_pipe[NSTG];
  end

  ami_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG_Q_SIZE (LOG_Q_SIZE)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail_vld),
    .push_data (tail_dat),
    .pop       (consume),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Response port is forced idle while rst is held.
  assign resp_vld         = !rst && !fifo_empty;
  assign consume          = resp_vld && bus.mem_resp_grant_in;
  assign bus.mem_resp_out = '{valid: resp_vld, data: resp_vld ? fifo_head : '0};

  // Credit counter: +1 per accepted read, -1 per consumed response.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (rd_fire && !consume) begin
      outstanding <= outstanding + CRED_ONE;
    end else if (!rd_fire && consume) begin
      outstanding <= outstanding - CRED_ONE;
    end
  end

  // The credit scheme must keep the FIFO from ever overflowing.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(tail_vld && fifo_full && !consume))
        else $error("ami_bram_responder: read pipeline pushed into full FIFO");
      assert (fifo_count <= outstanding)
        else $error("ami_bram_responder: FIFO holds more than outstanding credit");
    end
  end

endmodule

// File: tb/tb_ami_bram_responder.sv
// Scoreboard bench for ami_bram_responder: requests are issued from the main
// process, expected read data comes from a word-indexed reference array, and
// a negedge monitor checks responses as they are consumed.
module tb_ami_bram_responder;
  import AMITypes::*;

  localparam int LOG_SIZE     = 10;
  localparam int LOG_Q_SIZE   = 4;
  localparam int READ_LATENCY = 2;
  localparam int WORDS        = 1 << LOG_SIZE;
  localparam int DEPTH        = 1 << LOG_Q_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ami_bram_responder_if bus();

  ami_bram_responder #(
    .DATA_WIDTH   (512),
    .LOG_SIZE     (LOG_SIZE),
    .LOG_Q_SIZE   (LOG_Q_SIZE),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] data;
    longint       acc;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] model_mem [int];
  int           written[$];
  bit           exact_lat = 1'b0;
  bit           rand_bp   = 1'b0;
  bit           head_seen = 1'b0;
  bit           prev_hold = 1'b0;
  MemResp       prev_resp;
  int           n_resp    = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Word index: byte address divided by word size, wrapped to the array size.
  function automatic int widx(input logic [63:0] a);
    return int'((a / 64) % WORDS);
  endfunction

  // Random byte address landing on an already-written word (random high/low bits).
  function automatic logic [63:0] rd_addr();
    int i;
    i = written[$urandom_range(0, written.size() - 1)];
    return (64'($urandom) << 16) | 64'(i * 64) | 64'($urandom_range(0, 63));
  endfunction

  task automatic note_accept(input bit wr, input logic [63:0] a, input logic [511:0] d);
    int i;
    i = widx(a);
    if (wr) begin
      if (!model_mem.exists(i)) written.push_back(i);
      model_mem[i] = d;
    end else begin
      exp_q.push_back('{data: model_mem[i], acc: cyc});
    end
  endtask

  // Present one request and hold it until granted (bounded).
  task automatic issue(input bit wr, input logic [63:0] a, input logic [511:0] d, output longint acc);
    int w;
    w   = 0;
    acc = -1;
    bus.mem_req_in = '{valid: 1'b1, isWrite: wr, addr: a, data: d};
    forever begin
      @(negedge clk);
      if (bus.mem_req_grant_out) begin
        acc = cyc;
        note_accept(wr, a, d);
        @(posedge clk); #1;
        break;
      end
      w++;
      if (w > 300) begin
        check("req_grant_timeout", {511'd0, bus.mem_req_grant_out}, 512'd1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) bus.mem_resp_grant_in = ($urandom_range(0, 3) != 0);
    end
    if (rand_bp) bus.mem_resp_grant_in = ($urandom_range(0, 3) != 0);
    bus.mem_req_in.valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    bus.mem_resp_grant_in = 1'b1;
    while (exp_q.size() > 0 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_pending", 512'(exp_q.size()), 512'd0);
  endtask

  // Response monitor: latency, hold stability and in-order data.
  always @(negedge clk) begin
    longint lat;
    if (rst) begin
      head_seen = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("resp_hold_valid", {511'd0, bus.mem_resp_out.valid}, 512'd1);
        check("resp_hold_data", bus.mem_resp_out.data, prev_resp.data);
      end
      if (bus.mem_resp_out.valid) begin
        if (exp_q.size() == 0) begin
          check("resp_valid_when_idle", {511'd0, bus.mem_resp_out.valid}, 512'd0);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            lat = cyc - exp_q[0].acc;
            if (exact_lat) check("read_latency", 512'(lat), 512'(READ_LATENCY));
            else           check("min_latency", {511'd0, (lat >= READ_LATENCY)}, 512'd1);
          end
          if (bus.mem_resp_grant_in) begin
            check("resp_data", bus.mem_resp_out.data, exp_q[0].data);
            void'(exp_q.pop_front());
            head_seen = 1'b0;
            n_resp++;
          end
        end
      end
      prev_hold = bus.mem_resp_out.valid && !bus.mem_resp_grant_in;
      prev_resp = bus.mem_resp_out;
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc, acc_w, acc_r, first_acc, last_acc;
    int     acc_cnt, base, w;

    bus.mem_req_in        = '0;
    bus.mem_resp_grant_in = 1'b1;
    rst                   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp_valid", {511'd0, bus.mem_resp_out.valid}, 512'd0);
    check("reset_resp_data", bus.mem_resp_out.data, 512'd0);
    check("reset_grant", {511'd0, bus.mem_req_grant_out}, 512'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", {511'd0, bus.mem_req_grant_out}, 512'd1);
    @(posedge clk); #1;

    // Write then read back, exact latency
    for (int i = 0; i < 8; i++) issue(1'b1, 64'(i * 64), 512'(32'hDEAD0000 + i), acc);
    base      = n_resp;
    exact_lat = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b0, 64'(i * 64), 512'd0, acc);
    drain();
    exact_lat = 1'b0;
    check("wr_rd_resp_count", 512'(n_resp - base), 512'd8);
    check("wr_rd_word3", model_mem[3], 512'(32'hDEAD0003));

    // Read-after-write in consecutive cycles
    issue(1'b1, 64'h80, 512'h1234, acc_w);
    issue(1'b0, 64'h80, 512'd0, acc_r);
    check("raw_back_to_back", 512'(acc_r - acc_w), 512'd1);
    drain();

    // Address wrap
    issue(1'b1, 64'h0, 512'hA5, acc);
    issue(1'b0, 64'(1) << (LOG_SIZE + 6), 512'd0, acc);
    issue(1'b0, 64'h3F, 512'd0, acc);
    drain();

    // Backpressure: 20 reads presented, only DEPTH fit
    bus.mem_resp_grant_in = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_req_in = '{valid: 1'b1, isWrite: 1'b0, addr: rd_addr(), data: '0};
      @(negedge clk);
      if (bus.mem_req_grant_out) begin
        acc_cnt++;
        note_accept(1'b0, bus.mem_req_in.addr, '0);
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 512'(acc_cnt), 512'(DEPTH));
    bus.mem_req_in = '{valid: 1'b1, isWrite: 1'b0, addr: rd_addr(), data: '0};
    bus.mem_resp_grant_in = 1'b1;
    @(negedge clk);
    check("bp_grant_low_at_full", {511'd0, bus.mem_req_grant_out}, 512'd0);
    @(posedge clk); #1;
    bus.mem_resp_grant_in = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("bp_regrant", {511'd0, bus.mem_req_grant_out}, 512'd1);
      if (bus.mem_req_grant_out) begin
        acc_cnt++;
        note_accept(1'b0, bus.mem_req_in.addr, '0);
      end
      @(posedge clk); #1;
      bus.mem_req_in.addr = rd_addr();
    end
    check("bp_one_more", 512'(acc_cnt), 512'd1);
    bus.mem_req_in.valid = 1'b0;

    // Continuous reads starting at full credit: one accept per cycle
    bus.mem_resp_grant_in = 1'b1;
    acc_cnt   = 0;
    first_acc = -1;
    last_acc  = -1;
    w         = 0;
    while (acc_cnt < 100 && w < 400) begin
      bus.mem_req_in = '{valid: 1'b1, isWrite: 1'b0, addr: rd_addr(), data: '0};
      @(negedge clk);
      if (bus.mem_req_grant_out) begin
        if (acc_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
        note_accept(1'b0, bus.mem_req_in.addr, '0);
      end
      @(posedge clk); #1;
      w++;
    end
    bus.mem_req_in.valid = 1'b0;
    check("stream_accepts", 512'(acc_cnt), 512'd100);
    check("stream_no_stall", 512'(last_acc - first_acc), 512'd99);
    drain();

    // Reset with reads in flight
    bus.mem_resp_grant_in = 1'b0;
    for (int i = 0; i < 5; i++) issue(1'b0, 64'(i * 64), 512'd0, acc);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", {511'd0, bus.mem_resp_out.valid}, 512'd0);
    check("midrst_grant", {511'd0, bus.mem_req_grant_out}, 512'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_resp_grant_in = 1'b1;
    @(negedge clk);
    check("post_rst_grant", {511'd0, bus.mem_req_grant_out}, 512'd1);
    base = n_resp;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_resp", 512'(n_resp - base), 512'd0);
    issue(1'b0, 64'(3 * 64), 512'd0, acc);
    issue(1'b0, 64'h80, 512'd0, acc);
    drain();
    check("post_rst_readback", 512'(n_resp - base), 512'd2);

    // Randomized mix with random response backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 4)
        issue(1'b1, {$urandom, $urandom}, {16{$urandom}}, acc);
      else
        issue(1'b0, rd_addr(), 512'd0, acc);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        bus.mem_resp_grant_in = ($urandom_range(0, 3) != 0);
      end
    end
    rand_bp = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
